resta_display: RTL and testbench
================================

# resta_display

Registered result stage and 3-digit multiplexed seven-segment driver for the 4-bit subtractor. It sits directly downstream of the subtractor and captures `D`, `Overflow`, `Negative` and `Zero` on a load strobe. It shows the true signed difference (−15…+15, with sign, tens and units digits) on active-low common-anode displays, and drives overflow and zero LEDs.

## Interface
- `DIV`, default 50000: clock cycles each digit stays lit. Legal range is 2…2^20.
- `clk` input, 1 bit: system clock, rising edge.
- `rst_n` input, 1 bit: reset, asynchronous, active-low.
- `load` input, 1 bit: capture strobe, sampled on the rising edge of `clk`.
- `D` input, 4 bits: subtractor result, wrapped modulo 16.
- `Overflow` input, 1 bit: subtractor signed-overflow flag.
- `Negative` input, 1 bit: sign of the true difference.
- `Zero` input, 1 bit: result-zero flag.
- `an` output, 3 bits: digit enables, active-low. `an[0]` = units, `an[1]` = tens, `an[2]` = sign.
- `seg` output, 7 bits: segments `{g,f,e,d,c,b,a}`, active-low.
- `led_ovf` output, 1 bit: captured `Overflow`.
- `led_zero` output, 1 bit: captured `Zero`.

## Operation
- **Capture**
  - When `load`=1 on a rising edge, register `D`, `Overflow`, `Negative` and `Zero`.
  - When `load`=0, hold the registered values.
  - `load` held high recaptures on every edge.
- **Magnitude** (5-bit arithmetic)
  - `mag = Negative ? (16 − D) : D`.
  - This recovers the true value even when the 4-bit result wrapped on overflow. Examples: D=1 with N=1 gives −15; D=15 with N=0 gives +15.
  - The inconsistent input D=0 with N=1 gives mag=16 and displays "-16". It is not flagged.
- **Digit split**
  - `tens = mag ≥ 10 ? mag/10 : 0`; `units = mag mod 10`. tens is 0 or 1.
- **Digit content**
  - Units: always shown, `0`–`9`.
  - Tens: `1` if tens=1, otherwise blank (leading zero suppressed).
  - Sign: `-` if captured Negative=1, otherwise blank.
- **Segment codes** (gfedcba, active-low)
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - `-`=0111111, blank=1111111
- **Scan state machine**
  - Digit index `sel` cycles UNITS(0) → TENS(1) → SIGN(2) → UNITS.
  - Prescaler `cnt` counts 0…DIV−1 and wraps to 0. `sel` advances on the edge where `cnt`=DIV−1.
  - Exactly one `an` bit is low at a time: `an = ~(3'b001 << sel)`.
- **Outputs**
  - `an` and `seg` are registered, decoded from `sel` and the captured data.
  - `led_ovf` and `led_zero` are driven directly from the capture registers.

## Timing
- **Reset values** (`rst_n`=0, asynchronous)
  - `cnt`=0, `sel`=UNITS.
  - Captured D=0, Overflow=0, Negative=0, Zero=0.
  - `an`=111, `seg`=1111111, `led_ovf`=0, `led_zero`=0.
- **After reset release**
  - 1st rising edge: `an`=110, `seg`=1000000 (units "0").
  - Units stays lit for DIV edges, then tens (blank) for DIV edges, then sign (blank) for DIV edges, repeating.
- **Latency**
  - `led_*` follow a load edge with no extra cycle.
  - `an`/`seg` reflect new data 1 cycle after capture for the currently selected digit. Other digits update when scanned.
- **Simultaneous events**
  - A `load` on the same edge as a digit advance: the decode on the next edge uses both the new `sel` and the new data.
  - Capture does not reset `cnt` or `sel`.
- **Reset mid-operation**
  - `rst_n` low at any time immediately forces all reset values, including all digits off.
  - The scan restarts at UNITS with cnt=0.
- **Scan period**: 3·DIV cycles. No glitch states: `an` never has two bits low.

## Test plan
Use DIV=4 in all scenarios.
- **Reset**: rst_n=0 for 3 cycles, then release → during reset an=111, seg=1111111, leds 0. First edge after release: an=110, seg=1000000.
- **Positive, single digit**: load with D=0101, N=0, V=0, Z=0 → units seg=0010010, tens blank, sign blank, led_ovf=0.
- **Overflow, positive**: load with D=1111, N=0, V=1 (7−(−8)) → "15": units 0010010, tens 1111001, sign blank, led_ovf=1.
- **Overflow, negative**: load with D=0001, N=1, V=1 (−8−7) → "-15": sign 0111111, tens 1111001, units 0010010.
- **Zero and simple negative**: load with D=0000, Z=1 → units 1000000, led_zero=1. Then D=1111, N=1 → "-1", led_zero=0.
- **Scan and reset mid-scan**: verify sel dwell is exactly 4 cycles per digit and the period is 12 cycles. Assert rst_n low while the sign digit is lit → outputs return to reset values at once, and scan resumes at UNITS after release.

Source files
------------

// File: rtl/resta_display.sv
`default_nettype none
// ============================================================================
// Module   : resta_display
// Purpose  : Result register and 3-digit multiplexed seven-segment driver
//            for the 4-bit subtractor. Shows the true signed difference
//            (-16..+15) as sign / tens / units on active-low common-anode
//            digits and drives the overflow and zero LEDs.
// Revision : 1.0 - initial release
// ============================================================================
module resta_display #(
  parameter int DIV = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [3:0] D,
  input  logic       Overflow,
  input  logic       Negative,
  input  logic       Zero,
  output logic [2:0] an,
  output logic [6:0] seg,
  output logic       led_ovf,
  output logic       led_zero
);

  localparam int               CNT_W    = $clog2(DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

  localparam logic [1:0] SEL_UNITS = 2'd0;
  localparam logic [1:0] SEL_TENS  = 2'd1;
  localparam logic [1:0] SEL_SIGN  = 2'd2;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_ONE   = 7'b1111001;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       sel_q, sel_d;
  logic [3:0]       res_q, res_d;
  logic             ovf_q, ovf_d;
  logic             neg_q, neg_d;
  logic             zero_q, zero_d;
  logic [2:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;

  logic [4:0]       mag;
  logic             tens;
  logic [3:0]       units;

  // Decimal digit to active-low gfedcba pattern.
  function automatic logic [6:0] digit_seg(input logic [3:0] dig);
    logic [6:0] s;
    case (dig)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  // Capture the subtractor result on load, otherwise hold.
  always_comb begin
    res_d  = res_q;
    ovf_d  = ovf_q;
    neg_d  = neg_q;
    zero_d = zero_q;
    if (load) begin
      res_d  = D;
      ovf_d  = Overflow;
      neg_d  = Negative;
      zero_d = Zero;
    end
  end

  // Prescaler and digit selector: advance the digit once every DIV cycles.
  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    sel_d = sel_q;
    if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
      case (sel_q)
        SEL_UNITS: sel_d = SEL_TENS;
        SEL_TENS:  sel_d = SEL_SIGN;
        default:   sel_d = SEL_UNITS;
      endcase
    end
  end

  // Magnitude of the true difference; the sign bit undoes the 4-bit wrap.
  always_comb begin
    mag   = neg_q ? (5'd16 - {1'b0, res_q}) : {1'b0, res_q};
    tens  = (mag >= 5'd10);
    units = tens ? 4'(mag - 5'd10) : mag[3:0];
  end

  // Decode the currently selected digit into registered anode/segment drive.
  always_comb begin
    an_d  = 3'b111;
    seg_d = SEG_BLANK;
    case (sel_q)
      SEL_UNITS: begin
        an_d  = 3'b110;
        seg_d = digit_seg(units);
      end
      SEL_TENS: begin
        an_d  = 3'b101;
        seg_d = tens ? SEG_ONE : SEG_BLANK;
      end
      SEL_SIGN: begin
        an_d  = 3'b011;
        seg_d = neg_q ? SEG_DASH : SEG_BLANK;
      end
      default: begin
        an_d  = 3'b111;
        seg_d = SEG_BLANK;
      end
    endcase
  end

  // State registers with asynchronous active-low reset (all digits off).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      sel_q  <= SEL_UNITS;
      res_q  <= 4'd0;
      ovf_q  <= 1'b0;
      neg_q  <= 1'b0;
      zero_q <= 1'b0;
      an_q   <= 3'b111;
      seg_q  <= SEG_BLANK;
    end else begin
      cnt_q  <= cnt_d;
      sel_q  <= sel_d;
      res_q  <= res_d;
      ovf_q  <= ovf_d;
      neg_q  <= neg_d;
      zero_q <= zero_d;
      an_q   <= an_d;
      seg_q  <= seg_d;
    end
  end

  assign an       = an_q;
  assign seg      = seg_q;
  assign led_ovf  = ovf_q;
  assign led_zero = zero_q;

endmodule
`default_nettype wire

// File: tb/tb_resta_display.sv
`default_nettype none
// ============================================================================
// Module   : tb_resta_display
// Purpose  : Self-checking bench for resta_display (DIV=4) with an
//            expected-output queue filled as stimulus is driven.
// Revision : 1.0 - initial release
// ============================================================================
module tb_resta_display;

  localparam int DIV = 4;

  logic       clk;
  logic       rst_n;
  logic       load;
  logic [3:0] D;
  logic       Overflow;
  logic       Negative;
  logic       Zero;
  logic [2:0] an;
  logic [6:0] seg;
  logic       led_ovf;
  logic       led_zero;

  int n_assert = 0;
  int n_fail   = 0;

  logic [11:0] exp_q[$];
  string       tag_q[$];

  // Reference model state
  int         m_cnt;
  int         m_sel;
  logic [3:0] m_d;
  logic       m_n;
  logic       m_v;
  logic       m_z;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  resta_display #(.DIV(DIV)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .D        (D),
    .Overflow (Overflow),
    .Negative (Negative),
    .Zero     (Zero),
    .an       (an),
    .seg      (seg),
    .led_ovf  (led_ovf),
    .led_zero (led_zero)
  );

  function automatic logic [6:0] dig7(input int dig);
    case (dig)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic logic [2:0] model_an(input int sel);
    return ~(3'b001 << sel);
  endfunction

  function automatic logic [6:0] model_seg(input int sel, input logic [3:0] d, input logic n);
    int val;
    int mag;
    val = n ? (int'(d) - 16) : int'(d);
    mag = (val < 0) ? -val : val;
    if (sel == 0) return dig7(mag % 10);
    if (sel == 1) return (mag >= 10) ? 7'b1111001 : 7'b1111111;
    return n ? 7'b0111111 : 7'b1111111;
  endfunction

  task automatic model_reset();
    m_cnt = 0; m_sel = 0; m_d = 4'd0; m_n = 1'b0; m_v = 1'b0; m_z = 1'b0;
  endtask

  task automatic compare_pop(input logic [11:0] obs);
    logic [11:0] e;
    string       t;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    n_assert++;
    assert (obs === e) else begin
      n_fail++;
      $error("FAIL %s: observed an=%b seg=%b ovf=%b zero=%b expected an=%b seg=%b ovf=%b zero=%b",
             t, obs[11:9], obs[8:2], obs[1], obs[0], e[11:9], e[8:2], e[1], e[0]);
    end
  endtask

  // Drive one cycle of stimulus (called at a falling edge), queue the
  // expected post-edge outputs, then sample at the next falling edge.
  task automatic step(input logic ld, input logic [3:0] dd, input logic nn,
                      input logic vv, input logic zz, input string tag);
    logic [11:0] e;
    load = ld; D = dd; Negative = nn; Overflow = vv; Zero = zz;
    if (!rst_n) begin
      e = {3'b111, 7'b1111111, 1'b0, 1'b0};
    end else begin
      e[11:9] = model_an(m_sel);
      e[8:2]  = model_seg(m_sel, m_d, m_n);
      if (ld) begin m_d = dd; m_n = nn; m_v = vv; m_z = zz; end
      e[1] = m_v;
      e[0] = m_z;
      if (m_cnt == DIV - 1) begin m_cnt = 0; m_sel = (m_sel + 1) % 3; end
      else m_cnt++;
    end
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(posedge clk);
    @(negedge clk);
    compare_pop({an, seg, led_ovf, led_zero});
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) step(1'b0, D, Negative, Overflow, Zero, tag);
  endtask

  initial begin
    logic        found;
    logic [2:0]  exp_an;
    load = 1'b0; D = 4'd0; Overflow = 1'b0; Negative = 1'b0; Zero = 1'b0;
    model_reset();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    exp_q.push_back({3'b111, 7'b1111111, 1'b0, 1'b0});
    tag_q.push_back("reset_async");
    compare_pop({an, seg, led_ovf, led_zero});

    // Reset held for three cycles, then released
    idle(3, "reset_hold");
    rst_n = 1'b1;
    step(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, "first_edge");
    idle(11, "idle_zero");

    // +5
    step(1'b1, 4'b0101, 1'b0, 1'b0, 1'b0, "load_p5");
    idle(13, "show_p5");

    // +15 via overflow (7 - (-8))
    step(1'b1, 4'b1111, 1'b0, 1'b1, 1'b0, "load_p15");
    idle(13, "show_p15");

    // -15 via overflow (-8 - 7)
    step(1'b1, 4'b0001, 1'b1, 1'b1, 1'b0, "load_m15");
    idle(13, "show_m15");

    // zero, then -1
    step(1'b1, 4'b0000, 1'b0, 1'b0, 1'b1, "load_zero");
    idle(13, "show_zero");
    step(1'b1, 4'b1111, 1'b1, 1'b0, 1'b0, "load_m1");
    idle(13, "show_m1");

    // Inconsistent input shows -16
    step(1'b1, 4'b0000, 1'b1, 1'b0, 1'b0, "load_m16");
    idle(13, "show_m16");

    // load held high: recapture on every edge, across digit advances
    for (int i = 0; i < 14; i++)
      step(1'b1, 4'(i + 2), i[0], i[1], i[2], "load_held");
    idle(13, "show_held");

    // Wait for the sign digit, then reset asynchronously mid-scan
    found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      step(1'b0, D, Negative, Overflow, Zero, "seek_sign");
      if (an == 3'b011) found = 1'b1;
    end
    n_assert++;
    assert (found) else begin
      n_fail++;
      $error("FAIL seek_sign: observed sign digit lit=%b expected %b", found, 1'b1);
    end
    step(1'b0, D, Negative, Overflow, Zero, "sign_lit");
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    exp_q.push_back({3'b111, 7'b1111111, 1'b0, 1'b0});
    tag_q.push_back("reset_mid");
    compare_pop({an, seg, led_ovf, led_zero});
    @(negedge clk);
    idle(3, "reset_mid_hold");
    rst_n = 1'b1;

    // Scan must restart at units: 4 cycles per digit, 12-cycle period
    for (int k = 1; k <= 25; k++) begin
      step(1'b0, D, Negative, Overflow, Zero, "scan");
      exp_an = ~(3'b001 << (((k - 1) / DIV) % 3));
      n_assert++;
      assert (an === exp_an) else begin
        n_fail++;
        $error("FAIL scan_dwell: cycle %0d observed an=%b expected an=%b", k, an, exp_an);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
